mw_add_seq: RTL and testbench

//   Multi-word add sequencer. Adds two WORDS*N-bit operands by time-sharing one N-bit CLA

---
 rtl/mw_add_seq.sv | 188 ++++++++++++++++++
 tb/tb_mw_add_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_add_seq.sv
// ---------------------------------------------------------------------------
// mw_add_seq -- multi-word add sequencer
//
// Adds two W = N*WORDS bit operands using a single N-bit carry-lookahead
// adder, one word per cycle, least-significant word first.  The inter-word
// carry lives in a register between cycles.  Result, carry-out and signed
// overflow are presented with a one-cycle done pulse.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous reset, active low
//   start     request an operation (accepted only when idle)
//   C_in      carry into word 0, sampled with start
//   a, b      W-bit operands, sampled with start
//   busy      high whenever an operation is in flight (RUN or DONE)
//   done      one-cycle pulse; sum / C_out / overflow are valid
//   sum       W-bit result register
//   C_out     carry out of the top word
//   overflow  signed overflow of the full W-bit add
// ---------------------------------------------------------------------------

// N-bit carry-lookahead adder.  Every carry is expanded directly from the
// generate/propagate terms and c_in rather than rippling from its neighbour.
module cla #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c_in
  always_comb begin
    logic prod;
    c    = '0;
    prod = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & c_in);
    end
  end

  assign sum      = p ^ c[N-1:0];
  assign c_out    = c[N];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = c[N] ^ c[N-1];

endmodule

module mw_add_seq #(
  parameter  int N     = 8,
  parameter  int WORDS = 4,
  localparam int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         C_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         C_out,
  output logic         overflow
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_out_q, c_out_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  cla_sum;
  logic          cla_c_out;
  logic          cla_ovf;

  // The single shared adder always looks at the word selected by idx.
  cla #(.N(N)) u_cla (
    .x        (a_q[idx_q*N +: N]),
    .y        (b_q[idx_q*N +: N]),
    .c_in     (carry_q),
    .sum      (cla_sum),
    .c_out    (cla_c_out),
    .overflow (cla_ovf)
  );

  always_comb begin
    // NOTE: every signal written here is given a default first so no path
    // leaves it unassigned -- otherwise a latch would be inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = C_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*N +: N] = cla_sum;
        carry_d             = cla_c_out;
        idx_d               = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          // Only the top word's flags describe the full-width add.
          c_out_d = cla_c_out;
          ovf_d   = cla_ovf;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign C_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// ---------------------------------------------------------------------------
// tb_mw_add_seq -- self-checking bench for mw_add_seq (N=8, WORDS=4).
// Expected results come from plain (W+1)-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_mw_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  mw_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .C_in     (c_in),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .C_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {C_out,sum} = a + b + C_in, signed overflow from the sign bits.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         ci);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  // Launch one operation and wait (bounded) for done.  done_edge is the edge
  // number (start accepted at edge 0) where done was first seen, -1 on
  // timeout.  After acceptance the input operands are scrambled so any late
  // sampling of a/b/C_in shows up as a wrong result.
  task automatic do_op(input  logic [W-1:0] xa,
                       input  logic [W-1:0] xb,
                       input  logic         ci,
                       output int           done_edge,
                       output logic [W-1:0] got_sum,
                       output logic         got_c,
                       output logic         got_v,
                       output logic         done_after);
    @(negedge clk);
    start = 1'b1;
    a     = xa;
    b     = xb;
    c_in  = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    c_in  = 1'($urandom);
    done_edge = -1;
    got_sum   = '0;
    got_c     = 1'b0;
    got_v     = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_edge = e;
        got_sum   = sum;
        got_c     = c_out;
        got_v     = overflow;
        break;
      end
    end
    @(posedge clk);
    #1;
    done_after = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    c_in  = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    n_checks++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b done=%0b sum=%h C_out=%0b ovf=%0b, required all zero",
               busy, done, sum, c_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] va [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [W-1:0] vb [4] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000};
    logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [4] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000001};
    logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int           de;
    logic [W-1:0] gs;
    logic         gc, gv, da;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], de, gs, gc, gv, da);
      n_checks++;
      if (de !== WORDS) begin
        n_fail++;
        $display("FAIL directed%0d_done_edge: got %0d, required %0d", i, de, WORDS);
      end
      n_checks++;
      if (da !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_done_pulse: done=%0b one edge later, required 0", i, da);
      end
      n_checks++;
      if ({gc, gv, gs} !== {ec[i], ev[i], es[i]}) begin
        n_fail++;
        $display("FAIL directed%0d_result: sum=%h C_out=%0b ovf=%0b, required sum=%h C_out=%0b ovf=%0b",
                 i, gs, gc, gv, es[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [WORDS+1:0] busy_seen;
    logic [W-1:0]     sum_seen;
    logic             done_seen;
    busy_seen = '0;
    sum_seen  = '0;
    done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 32'd5;
    b     = 32'd3;
    c_in  = 1'b0;
    @(posedge clk);           // edge 0
    #1;
    busy_seen[0] = busy;
    start = 1'b0;
    for (int e = 1; e <= WORDS + 1; e++) begin
      if (e == 2) begin
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd100;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      busy_seen[e] = busy;
      if (e == WORDS) begin
        done_seen = done;
        sum_seen  = sum;
      end
    end
    n_checks++;
    if (busy_seen !== {1'b0, {(WORDS+1){1'b1}}}) begin
      n_fail++;
      $display("FAIL busy_window: busy after edges 0..%0d = %b (lsb=edge0), required %b",
               WORDS + 1, busy_seen, {1'b0, {(WORDS+1){1'b1}}});
    end
    n_checks++;
    if ({done_seen, sum_seen} !== {1'b1, 32'd8}) begin
      n_fail++;
      $display("FAIL start_while_busy: done=%0b sum=%0d at edge %0d, required done=1 sum=8",
               done_seen, sum_seen, WORDS);
    end
    // The ignored start must not have been queued.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h12345678;
    b     = 32'h11111111;
    c_in  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%0b done=%0b sum=%h C_out=%0b ovf=%0b, required all zero",
               busy, done, sum, c_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Nothing in flight after release.
    repeat (WORDS + 2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] xa, xb, gs;
    logic         ci, gc, gv, da;
    logic [W+1:0] exp_r;
    int           de;
    for (int i = 0; i < 200; i++) begin
      xa = $urandom;
      xb = $urandom;
      ci = 1'($urandom);
      // Bias some operands toward the sign boundary to hit overflow often.
      if (i % 4 == 1) xa[W-1:W-2] = {xa[W-1], ~xa[W-1]};
      if (i % 4 == 1) xb[W-1:W-2] = {xa[W-1], ~xa[W-1]};
      exp_r = ref_add(xa, xb, ci);
      do_op(xa, xb, ci, de, gs, gc, gv, da);
      n_checks++;
      if (de !== WORDS || da !== 1'b0 || {gv, gc, gs} !== exp_r) begin
        n_fail++;
        $display("FAIL random%0d: a=%h b=%h cin=%0b -> done_edge=%0d pulse_after=%0b sum=%h C_out=%0b ovf=%0b, required done_edge=%0d sum=%h C_out=%0b ovf=%0b",
                 i, xa, xb, ci, de, da, gs, gc, gv, WORDS, exp_r[W-1:0], exp_r[W], exp_r[W+1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
